// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for a short in-order pipeline: detects load-use stalls,
// PC-write and branch flushes, and selects the Execute operand forwarding source.
module pipe_hazard_ctrl #(
   parameter int NREG       = 16,
   parameter int DEPTH      = 3,
   parameter int LOAD_STAGE = 2,
   parameter int PC_REG     = 15,
   parameter int CNT_W      = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     dec_valid,
   input  logic [$clog2(NREG)-1:0]  dec_ra1,
   input  logic [$clog2(NREG)-1:0]  dec_ra2,
   input  logic                     dec_use1,
   input  logic                     dec_use2,
   input  logic [$clog2(NREG)-1:0]  dec_rd,
   input  logic                     dec_wr,
   input  logic                     dec_load,
   input  logic                     dec_pcwr,
   input  logic                     br_taken,
   input  logic                     cnt_clr,
   output logic [$clog2(DEPTH)-1:0] fwd_a,
   output logic [$clog2(DEPTH)-1:0] fwd_b,
   output logic                     stall_f,
   output logic                     stall_d,
   output logic                     flush_d,
   output logic                     flush_e,
   output logic [CNT_W-1:0]         stall_cnt,
   output logic [CNT_W-1:0]         flush_cnt
);
   localparam int RW = $clog2(NREG);
   localparam int FW = $clog2(DEPTH);
   localparam logic [RW-1:0] PC_IDX = RW'(PC_REG);

   typedef struct packed {
      logic          valid;
      logic [RW-1:0] rd;
      logic          wr;
      logic          load;
      logic          pcwr;
   } entry_t;

   entry_t        stage_reg [DEPTH];
   logic [RW-1:0] ra1_reg;
   logic [RW-1:0] ra2_reg;
   logic          use1_reg;
   logic          use2_reg;

   entry_t           dec_entry;
   logic [DEPTH-1:0] wr_live;
   logic [DEPTH-1:0] dec_m1;
   logic [DEPTH-1:0] dec_m2;
   logic [DEPTH-1:0] ld_hit;
   logic [DEPTH-1:0] pc_hit;
   logic [DEPTH-1:1] cand_a;
   logic [DEPTH-1:1] cand_b;
   logic             ldstall;
   logic             pcwr_pend;
   logic             flush_e_int;
   logic [FW-1:0]    fwd_a_next;
   logic [FW-1:0]    fwd_b_next;

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_stage
         localparam bit STALL_ZONE = (gi <= LOAD_STAGE - 2);
         localparam bit IN_FLIGHT  = (gi <= DEPTH - 2);
         assign wr_live[gi] = stage_reg[gi].valid & stage_reg[gi].wr;
         assign dec_m1[gi]  = wr_live[gi] & (stage_reg[gi].rd == dec_ra1) & (dec_ra1 != PC_IDX);
         assign dec_m2[gi]  = wr_live[gi] & (stage_reg[gi].rd == dec_ra2) & (dec_ra2 != PC_IDX);
         assign ld_hit[gi]  = STALL_ZONE & stage_reg[gi].load &
                              ((dec_use1 & dec_m1[gi]) | (dec_use2 & dec_m2[gi]));
         assign pc_hit[gi]  = IN_FLIGHT & stage_reg[gi].valid & stage_reg[gi].pcwr;
      end

      // Loads still short of LOAD_STAGE have no data yet, so they are skipped over.
      for (gi = 1; gi < DEPTH; gi++) begin : g_fwd
         localparam bit EARLY = (gi < LOAD_STAGE);
         logic usable;
         assign usable     = wr_live[gi] & ~(EARLY & stage_reg[gi].load);
         assign cand_a[gi] = stage_reg[0].valid & use1_reg & usable &
                             (stage_reg[gi].rd == ra1_reg) & (ra1_reg != PC_IDX);
         assign cand_b[gi] = stage_reg[0].valid & use2_reg & usable &
                             (stage_reg[gi].rd == ra2_reg) & (ra2_reg != PC_IDX);
      end
   endgenerate

   assign ldstall     = dec_valid & ~br_taken & (|ld_hit);
   assign pcwr_pend   = (dec_valid & dec_pcwr) | (|pc_hit);
   assign flush_e_int = ldstall | br_taken;

   always_comb begin
      fwd_a_next = '0;
      fwd_b_next = '0;
      for (int k = DEPTH - 1; k >= 1; k--) begin
         if (cand_a[k]) fwd_a_next = FW'(k);
         if (cand_b[k]) fwd_b_next = FW'(k);
      end
   end

   // Outputs are gated so they read 0 while reset is held, whatever the inputs do.
   assign stall_f = reset & (ldstall | pcwr_pend);
   assign stall_d = reset & ldstall;
   assign flush_d = reset & (pcwr_pend | br_taken |
                             (stage_reg[DEPTH-1].valid & stage_reg[DEPTH-1].pcwr));
   assign flush_e = reset & flush_e_int;
   assign fwd_a   = reset ? fwd_a_next : '0;
   assign fwd_b   = reset ? fwd_b_next : '0;

   assign dec_entry = '{valid: dec_valid & ~flush_e_int, rd: dec_rd, wr: dec_wr,
                        load: dec_load, pcwr: dec_pcwr};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int k = 0; k < DEPTH; k++) stage_reg[k] <= '0;
         ra1_reg  <= '0;
         ra2_reg  <= '0;
         use1_reg <= 1'b0;
         use2_reg <= 1'b0;
      end else begin
         stage_reg[0] <= dec_entry;
         for (int k = 1; k < DEPTH; k++) stage_reg[k] <= stage_reg[k-1];
         ra1_reg  <= dec_ra1;
         ra2_reg  <= dec_ra2;
         use1_reg <= dec_use1;
         use2_reg <= dec_use2;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else if (cnt_clr) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (ldstall && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
         if (br_taken && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
      end
   end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized and directed checks of pipe_hazard_ctrl against an instruction-history
// model; a second instance with 4-bit counters exercises saturation.
module tb_pipe_hazard_ctrl;
   localparam int DEPTH      = 3;
   localparam int LOAD_STAGE = 2;
   localparam int PC_R       = 15;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset;
   logic       dec_valid, dec_use1, dec_use2, dec_wr, dec_load, dec_pcwr, br_taken, cnt_clr;
   logic [3:0] dec_ra1, dec_ra2, dec_rd;
   logic [1:0] fwd_a, fwd_b, fwd_a4, fwd_b4;
   logic       stall_f, stall_d, flush_d, flush_e;
   logic       stall_f4, stall_d4, flush_d4, flush_e4;
   logic [15:0] stall_cnt, flush_cnt;
   logic [3:0]  stall_cnt4, flush_cnt4;

   pipe_hazard_ctrl dut (
      .clk(clk), .reset(reset), .dec_valid(dec_valid), .dec_ra1(dec_ra1), .dec_ra2(dec_ra2),
      .dec_use1(dec_use1), .dec_use2(dec_use2), .dec_rd(dec_rd), .dec_wr(dec_wr),
      .dec_load(dec_load), .dec_pcwr(dec_pcwr), .br_taken(br_taken), .cnt_clr(cnt_clr),
      .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_f(stall_f), .stall_d(stall_d),
      .flush_d(flush_d), .flush_e(flush_e), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));

   pipe_hazard_ctrl #(.CNT_W(4)) dut4 (
      .clk(clk), .reset(reset), .dec_valid(dec_valid), .dec_ra1(dec_ra1), .dec_ra2(dec_ra2),
      .dec_use1(dec_use1), .dec_use2(dec_use2), .dec_rd(dec_rd), .dec_wr(dec_wr),
      .dec_load(dec_load), .dec_pcwr(dec_pcwr), .br_taken(br_taken), .cnt_clr(cnt_clr),
      .fwd_a(fwd_a4), .fwd_b(fwd_b4), .stall_f(stall_f4), .stall_d(stall_d4),
      .flush_d(flush_d4), .flush_e(flush_e4), .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4));

   typedef struct {
      bit v; int rd; bit wr; bit ld; bit pc;
   } ent_t;

   ent_t pipe_q[$];          // instructions that entered Execute, newest first
   int   n_vec = 0;
   int   n_bad = 0;
   bit   e_ldstall, e_pcpend, e_flush_d, e_flush_e;
   int   e_fwd_a, e_fwd_b;
   int   e_scnt = 0, e_fcnt = 0, e_scnt4 = 0, e_fcnt4 = 0;
   int   ex_ra1, ex_ra2;
   bit   ex_u1, ex_u2;
   int   gaps_exp [3] = '{1, 2, 0};
   bit   sf_exp [5]   = '{1, 1, 1, 0, 0};
   bit   fd_exp [5]   = '{1, 1, 1, 1, 0};

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic ent_t stage_at(int k);
      ent_t e;
      e = '{default: 0};
      if (k < pipe_q.size()) e = pipe_q[k];
      return e;
   endfunction

   function automatic bit produces(int r, int k);
      ent_t s;
      s = stage_at(k);
      return s.v && s.wr && (s.rd == r) && (r != PC_R);
   endfunction

   function automatic int nearest(int r);
      ent_t s;
      for (int k = 1; k < DEPTH; k++) begin
         s = stage_at(k);
         if (produces(r, k) && !(s.ld && k < LOAD_STAGE)) return k;
      end
      return 0;
   endfunction

   function automatic void model_eval();
      ent_t s;
      bit   hz;
      hz = 0;
      for (int k = 0; k < LOAD_STAGE - 1; k++) begin
         s = stage_at(k);
         if (s.ld && ((dec_use1 && produces(int'(dec_ra1), k)) ||
                      (dec_use2 && produces(int'(dec_ra2), k)))) hz = 1;
      end
      e_ldstall = dec_valid && !br_taken && hz;
      e_pcpend  = dec_valid && dec_pcwr;
      for (int k = 0; k < DEPTH - 1; k++) begin
         s = stage_at(k);
         if (s.v && s.pc) e_pcpend = 1;
      end
      s = stage_at(DEPTH - 1);
      e_flush_d = e_pcpend || (s.v && s.pc) || br_taken;
      e_flush_e = e_ldstall || br_taken;
      s = stage_at(0);
      e_fwd_a = (s.v && ex_u1) ? nearest(ex_ra1) : 0;
      e_fwd_b = (s.v && ex_u2) ? nearest(ex_ra2) : 0;
   endfunction

   function automatic void model_commit();
      ent_t n;
      n.v  = dec_valid && !e_flush_e;
      n.rd = int'(dec_rd);
      n.wr = dec_wr;
      n.ld = dec_load;
      n.pc = dec_pcwr;
      pipe_q.push_front(n);
      if (pipe_q.size() > DEPTH) void'(pipe_q.pop_back());
      ex_ra1 = int'(dec_ra1);
      ex_ra2 = int'(dec_ra2);
      ex_u1  = dec_use1;
      ex_u2  = dec_use2;
      if (cnt_clr) begin
         e_scnt = 0; e_fcnt = 0; e_scnt4 = 0; e_fcnt4 = 0;
      end else begin
         if (e_ldstall && e_scnt < 65535) e_scnt++;
         if (e_ldstall && e_scnt4 < 15) e_scnt4++;
         if (br_taken && e_fcnt < 65535) e_fcnt++;
         if (br_taken && e_fcnt4 < 15) e_fcnt4++;
      end
   endfunction

   // Compare both instances mid-cycle, then advance one clock.
   task automatic cycle();
      @(negedge clk);
      model_eval();
      check_val("stall_f", 32'(stall_f), 32'(e_ldstall | e_pcpend));
      check_val("stall_d", 32'(stall_d), 32'(e_ldstall));
      check_val("flush_d", 32'(flush_d), 32'(e_flush_d));
      check_val("flush_e", 32'(flush_e), 32'(e_flush_e));
      check_val("fwd_a", 32'(fwd_a), 32'(e_fwd_a));
      check_val("fwd_b", 32'(fwd_b), 32'(e_fwd_b));
      check_val("stall_cnt", 32'(stall_cnt), 32'(e_scnt));
      check_val("flush_cnt", 32'(flush_cnt), 32'(e_fcnt));
      check_val("ctrl4", {28'd0, stall_f4, stall_d4, flush_d4, flush_e4},
                {28'd0, e_ldstall | e_pcpend, e_ldstall, e_flush_d, e_flush_e});
      check_val("fwd4", {28'd0, fwd_a4, fwd_b4}, 32'((e_fwd_a << 2) | e_fwd_b));
      check_val("stall_cnt4", 32'(stall_cnt4), 32'(e_scnt4));
      check_val("flush_cnt4", 32'(flush_cnt4), 32'(e_fcnt4));
      @(posedge clk);
      model_commit();
      #1;
   endtask

   task automatic zero_check(input string tag);
      check_val({tag, "_ctrl"}, {28'd0, stall_f, stall_d, flush_d, flush_e}, 32'd0);
      check_val({tag, "_fwd"}, {28'd0, fwd_a, fwd_b}, 32'd0);
      check_val({tag, "_cnt"}, {stall_cnt, flush_cnt}, 32'd0);
      check_val({tag, "_cnt4"}, {24'd0, stall_cnt4, flush_cnt4}, 32'd0);
   endtask

   // Asserts reset between edges with active inputs, then releases it after one edge.
   task automatic reset_check(input string tag);
      dec_valid = 1'b1; dec_pcwr = 1'b1; br_taken = 1'b1;
      #1 reset = 1'b0;
      #1 zero_check(tag);
      @(posedge clk);
      #1 reset = 1'b1;
      pipe_q.delete();
      e_scnt = 0; e_fcnt = 0; e_scnt4 = 0; e_fcnt4 = 0;
   endtask

   function automatic logic [3:0] pick_reg();
      int r;
      r = int'($urandom_range(0, 4));
      return (r == 4) ? 4'd15 : 4'(r);
   endfunction

   task automatic drive(input bit dv, input int rd, input bit wr, input bit ld, input bit pc,
                        input int ra1, input bit u1, input int ra2, input bit u2);
      dec_valid = dv; dec_rd = 4'(rd); dec_wr = wr; dec_load = ld; dec_pcwr = pc;
      dec_ra1 = 4'(ra1); dec_use1 = u1; dec_ra2 = 4'(ra2); dec_use2 = u2;
      br_taken = 1'b0; cnt_clr = 1'b0;
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic drain();
      idle();
      repeat (DEPTH + 1) cycle();
   endtask

   initial begin
      bit hold;
      int base_s, base_f;
      hold = 0;
      idle();
      reset = 1'b0;
      #12 zero_check("por");
      @(posedge clk);
      #1 reset = 1'b1;

      for (int i = 0; i < 3000; i++) begin
         if (!hold) begin
            dec_valid = ($urandom_range(0, 7) != 0);
            dec_rd    = pick_reg();
            dec_ra1   = pick_reg();
            dec_ra2   = pick_reg();
            dec_use1  = ($urandom_range(0, 3) != 0);
            dec_use2  = ($urandom_range(0, 1) == 1);
            dec_wr    = ($urandom_range(0, 3) != 0);
            dec_load  = dec_wr && ($urandom_range(0, 2) == 0);
            dec_pcwr  = ($urandom_range(0, 19) == 0);
         end
         br_taken = ($urandom_range(0, 9) == 0);
         cnt_clr  = ($urandom_range(0, 399) == 0);
         if (i % 800 == 400) reset_check("rst_mid");
         cycle();
         hold = e_ldstall;
      end

      // Reset with a full pipeline.
      drain();
      repeat (3) begin drive(1, 1, 1, 0, 0, 0, 0, 0, 0); cycle(); end
      reset_check("rst_full");
      idle();

      // Forwarding distance with 0, 1 and 2 gaps.
      for (int g = 0; g < 3; g++) begin
         drain();
         drive(1, 1, 1, 0, 0, 0, 0, 0, 0); cycle();
         repeat (g) begin idle(); cycle(); end
         drive(1, 4, 1, 0, 0, 1, 1, 1, 1); cycle();
         idle(); #1;
         check_val("gap_fwd_a", 32'(fwd_a), 32'(gaps_exp[g]));
         check_val("gap_fwd_b", 32'(fwd_b), 32'(gaps_exp[g]));
      end

      // Load-use: one stall cycle then forward from stage 2.
      drain();
      drive(1, 2, 1, 1, 0, 0, 0, 0, 0); cycle();
      drive(1, 3, 1, 0, 0, 2, 1, 0, 0); #1;
      check_val("lu_stall", {29'd0, stall_f, stall_d, flush_e}, 32'd7);
      base_s = e_scnt;
      cycle(); #1;
      check_val("lu_release", 32'(stall_d), 32'd0);
      check_val("lu_cnt", 32'(stall_cnt), 32'(base_s + 1));
      cycle();
      idle(); #1;
      check_val("lu_fwd", 32'(fwd_a), 32'd2);

      // Branch wins over a load-use condition.
      drain();
      drive(1, 2, 1, 1, 0, 0, 0, 0, 0); cycle();
      drive(1, 3, 1, 0, 0, 2, 1, 0, 0); br_taken = 1'b1; #1;
      check_val("br_ctrl", {29'd0, flush_d, flush_e, stall_d}, 32'd6);
      base_s = e_scnt;
      base_f = e_fcnt;
      cycle(); #1;
      check_val("br_fcnt", 32'(flush_cnt), 32'(base_f + 1));
      check_val("br_scnt", 32'(stall_cnt), 32'(base_s));

      // PC write in decode: stall_f for 3 cycles, flush_d for 4.
      drain();
      drive(1, 5, 0, 0, 1, 0, 0, 0, 0); #1;
      for (int c = 0; c < 5; c++) begin
         check_val("pc_stall_f", 32'(stall_f), 32'(sf_exp[c]));
         check_val("pc_flush_d", 32'(flush_d), 32'(fd_exp[c]));
         cycle();
         idle(); #1;
      end

      // PC register is never forwarded.
      drain();
      drive(1, 15, 1, 0, 0, 0, 0, 0, 0); cycle();
      drive(1, 6, 1, 0, 0, 15, 1, 0, 0); cycle();
      idle(); #1;
      check_val("pc_nofwd", 32'(fwd_a), 32'd0);

      // Twenty stalls saturate the 4-bit counter; clear returns both to zero.
      idle(); cnt_clr = 1'b1; cycle();
      for (int p = 0; p < 20; p++) begin
         drive(1, 2, 1, 1, 0, 0, 0, 0, 0); cycle();
         drive(1, 3, 1, 0, 0, 2, 1, 0, 0); cycle(); cycle();
      end
      check_val("sat_cnt4", 32'(stall_cnt4), 32'd15);
      check_val("sat_cnt16", 32'(stall_cnt), 32'd20);
      idle(); cnt_clr = 1'b1; cycle();
      cnt_clr = 1'b0; #1;
      check_val("clr_cnt4", 32'(stall_cnt4), 32'd0);
      check_val("clr_cnt16", 32'(stall_cnt), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
